// File: rtl/datapath_pkg.sv
// datapath_pkg: constants and helper functions shared by the datapath blocks.
//   NUM_REGS / REG_ADDR_W : register-file geometry
//   DEFAULT_WIDTH         : default register data width
//   is_onehot8            : 1 only when exactly one of the 8 bits is set
//   is_multihot8          : 1 when two or more of the 8 bits are set
package datapath_pkg;

  localparam int unsigned NUM_REGS      = 8;
  localparam int unsigned REG_ADDR_W    = 3;
  localparam int unsigned DEFAULT_WIDTH = 16;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  function automatic logic is_onehot8(input logic [7:0] v);
    return popcount8(v) == 4'd1;
  endfunction

  function automatic logic is_multihot8(input logic [7:0] v);
    return popcount8(v) > 4'd1;
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational 8:1 read port of the register file.
//   regs  : flattened register array contents
//   addr  : read address
//   wsel  : write-select bus (used for bypass)
//   wdata : write data (used for bypass)
//   rd    : read data
module rf_read_port
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter bit          R0_ZERO = 1'b1,
  parameter bit          BYPASS  = 1'b0
) (
  input  logic [NUM_REGS-1:0][WIDTH-1:0] regs,
  input  logic [REG_ADDR_W-1:0]          addr,
  input  logic [NUM_REGS-1:0]            wsel,
  input  logic [WIDTH-1:0]               wdata,
  output logic [WIDTH-1:0]               rd
);

  logic addr_is_r0;
  logic bypass_hit;

  always_comb begin
    addr_is_r0 = (addr == '0);
    // Forward only a write that will really land: one-hot, aimed here, not a discarded R0 write.
    bypass_hit = BYPASS && is_onehot8(wsel) && wsel[addr] && !(R0_ZERO && addr_is_r0);

    rd = regs[addr];
    if (bypass_hit) begin
      rd = wdata;
    end
    if (R0_ZERO && addr_is_r0) begin
      rd = '0;
    end
  end

endmodule

// File: rtl/reg_file8.sv
// reg_file8: eight-entry register file with two combinational read ports.
//   clk, rst     : clock, synchronous active-high reset
//   wsel, wdata  : one-hot write select from the write decoder, write data
//   ra, rb       : read addresses; rd_a, rd_b : read data
//   err_clr, err : clear / sticky flag for a multi-hot write select
module reg_file8
  import datapath_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter bit          R0_ZERO = 1'b1,
  parameter bit          BYPASS  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REGS-1:0]   wsel,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic [REG_ADDR_W-1:0] rb,
  output logic [WIDTH-1:0]      rd_a,
  output logic [WIDTH-1:0]      rd_b,
  input  logic                  err_clr,
  output logic                  err
);

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            wr_en;
  logic                           err_q, err_d;

  always_comb begin
    // Zero-hot and multi-hot selects both write nothing; multi-hot is never partially applied.
    wr_en = is_onehot8(wsel) ? wsel : '0;
    if (R0_ZERO) begin
      wr_en[0] = 1'b0;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = wr_en[i] ? wdata : regs_q[i];
    end
  end

  // A new multi-hot event takes priority over a clear on the same edge.
  always_comb begin
    err_d = err_q;
    if (is_multihot8(wsel)) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      err_q  <= 1'b0;
    end else begin
      regs_q <= regs_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

  rf_read_port #(
    .WIDTH   (WIDTH),
    .R0_ZERO (R0_ZERO),
    .BYPASS  (BYPASS)
  ) u_port_a (
    .regs  (regs_q),
    .addr  (ra),
    .wsel  (wsel),
    .wdata (wdata),
    .rd    (rd_a)
  );

  rf_read_port #(
    .WIDTH   (WIDTH),
    .R0_ZERO (R0_ZERO),
    .BYPASS  (BYPASS)
  ) u_port_b (
    .regs  (regs_q),
    .addr  (rb),
    .wsel  (wsel),
    .wdata (wdata),
    .rd    (rd_b)
  );

endmodule
